vx_dma_engine: RTL and testbench

- Responder end of the core's DMA bus. Accepts copy commands (warp id, source, destination, byte size) issued by the SFU DMA unit.
- Performs a word-by-word memory-to-memory copy over a simple valid/ready memory port.
- Returns a completion response tagged with the issuing warp id, which the SFU side uses to release that warp's stall.
- Sits between the core's DMA bus and the core-side memory arbiter; handles one command at a time.

---
 rtl/vx_dma_engine.sv | 161 ++++++++++++++++
 tb/tb_vx_dma_engine.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_dma_engine.sv
// vx_dma_engine: responder end of the core DMA bus.
// Takes one copy command at a time and moves it word by word over the memory
// port (read, then write, ascending addresses). When the copy is done it
// returns a completion tagged with the issuing warp id.
//
// Handshake rule for every channel (req, rsp, mem_req, mem_rsp): a transfer
// happens on a rising clk edge where valid && ready. The valid side keeps
// valid and its payload steady until that edge. Every output here comes
// straight from a register, so no input reaches an output combinationally.
module vx_dma_engine #(
  parameter int NUM_WARPS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 32,
  parameter int WORD_SIZE  = 4,
  parameter int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int DATA_WIDTH = 8 * WORD_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NW_BITS-1:0]    req_wid,
  input  logic [ADDR_WIDTH-1:0] req_src,
  input  logic [ADDR_WIDTH-1:0] req_dst,
  input  logic [SIZE_WIDTH-1:0] req_size,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NW_BITS-1:0]    rsp_wid,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  output logic [WORD_SIZE-1:0]  mem_req_byteen,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  busy
);

  localparam int OFFS = $clog2(WORD_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(WORD_SIZE - 1));
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(WORD_SIZE);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                state;
  logic [NW_BITS-1:0]    wid_r;
  logic [ADDR_WIDTH-1:0] src_r;
  logic [ADDR_WIDTH-1:0] dst_r;
  logic [SIZE_WIDTH-1:0] remaining;

  // Whole words in the incoming command; a trailing partial word is dropped.
  logic [SIZE_WIDTH-1:0] req_words;
  assign req_words = req_size >> OFFS;

  // Every transfer writes the full word.
  assign mem_req_byteen = '1;

  // Copy sequencer. Each output register is loaded with the value that
  // belongs to the state being entered, so it stays steady for that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wid_r         <= '0;
      src_r         <= '0;
      dst_r         <= '0;
      remaining     <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_wid       <= '0;
      mem_req_valid <= 1'b0;
      mem_req_rw    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_rsp_ready <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            wid_r     <= req_wid;
            src_r     <= req_src & ALIGN_MASK;
            dst_r     <= req_dst & ALIGN_MASK;
            remaining <= req_words;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_words == '0) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_wid   <= req_wid;
            end else begin
              state         <= RD_REQ;
              mem_req_valid <= 1'b1;
              mem_req_rw    <= 1'b0;
              mem_req_addr  <= req_src & ALIGN_MASK;
            end
          end
        end
        RD_REQ: begin
          if (mem_req_ready) begin
            state         <= RD_WAIT;
            mem_req_valid <= 1'b0;
            mem_rsp_ready <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (mem_rsp_valid) begin
            state         <= WR_REQ;
            mem_rsp_ready <= 1'b0;
            mem_req_valid <= 1'b1;
            mem_req_rw    <= 1'b1;
            mem_req_addr  <= dst_r;
            mem_req_data  <= mem_rsp_data;
          end
        end
        WR_REQ: begin
          if (mem_req_ready) begin
            src_r     <= src_r + STEP;
            dst_r     <= dst_r + STEP;
            remaining <= remaining - SIZE_WIDTH'(1);
            if (remaining == SIZE_WIDTH'(1)) begin
              state         <= DONE;
              mem_req_valid <= 1'b0;
              rsp_valid     <= 1'b1;
              rsp_wid       <= wid_r;
            end else begin
              state         <= RD_REQ;
              mem_req_valid <= 1'b1;
              mem_req_rw    <= 1'b0;
              mem_req_addr  <= src_r + STEP;
            end
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          req_ready     <= 1'b1;
          rsp_valid     <= 1'b0;
          mem_req_valid <= 1'b0;
          mem_rsp_ready <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vx_dma_engine.sv
// Testbench for vx_dma_engine.
// The memory model is word-addressed: it answers reads, applies writes and
// logs every memory transfer. For each command, a copy model built from
// plain address arithmetic on a snapshot of memory predicts the read
// addresses, the write addresses and data, and the final destination
// contents.
module tb_vx_dma_engine;

  localparam int NW = 2;
  localparam int AW = 32;
  localparam int SW = 32;
  localparam int DW = 32;
  localparam int WS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [NW-1:0] req_wid;
  logic [AW-1:0] req_src;
  logic [AW-1:0] req_dst;
  logic [SW-1:0] req_size;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [NW-1:0] rsp_wid;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b1;
  logic          mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [WS-1:0] mem_req_byteen;
  logic          mem_rsp_valid = 1'b0;
  logic          mem_rsp_ready;
  logic [DW-1:0] mem_rsp_data  = '0;
  logic          busy;

  vx_dma_engine #(
    .NUM_WARPS (4),
    .ADDR_WIDTH(AW),
    .SIZE_WIDTH(SW),
    .WORD_SIZE (WS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wid       (req_wid),
    .req_src       (req_src),
    .req_dst       (req_dst),
    .req_size      (req_size),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_wid       (rsp_wid),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_rw    (mem_req_rw),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_byteen(mem_req_byteen),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp_data  (mem_rsp_data),
    .busy          (busy)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] mem     [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h0001};
  endfunction

  function automatic logic [DW-1:0] mem_get(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return fill(a);
  endfunction

  function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return fill(a);
  endfunction

  logic [AW-1:0] exp_rd_q[$];
  logic [AW-1:0] exp_wa_q[$];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  logic [DW-1:0] rsp_q[$];

  // ---------------- memory model ----------------
  // The model acts at the falling edge. It picks the ready/valid inputs that
  // will apply at the next rising edge, and then logs whatever transfers that
  // edge will perform.
  bit            stall_mode = 1'b0;
  logic          hold_v = 1'b0;
  logic          hold_rw;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;

  always @(negedge clk) begin
    if (reset) begin
      rsp_q.delete();
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      hold_v        = 1'b0;
    end else begin
      if (hold_v) begin
        check("mreq_hold_valid", mem_req_valid, 1);
        check("mreq_hold_rw", mem_req_rw, hold_rw);
        check("mreq_hold_addr", mem_req_addr, hold_addr);
        check("mreq_hold_data", mem_req_data, hold_data);
      end
      mem_req_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rsp_q.size() != 0 && (!stall_mode || $urandom_range(0, 2) != 0)) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rsp_q[0];
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
      end
      if (mem_rsp_valid && mem_rsp_ready) void'(rsp_q.pop_front());
      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_rw) begin
          mem[mem_req_addr] = mem_req_data;
          wr_addr_log.push_back(mem_req_addr);
          wr_data_log.push_back(mem_req_data);
        end else begin
          rd_log.push_back(mem_req_addr);
          rsp_q.push_back(mem_get(mem_req_addr));
        end
      end
      hold_v    = mem_req_valid && !mem_req_ready;
      hold_rw   = mem_req_rw;
      hold_addr = mem_req_addr;
      hold_data = mem_req_data;
    end
  end

  // ---------------- driver ----------------
  // Issues one command (called at a falling edge with the engine idle) and
  // checks the whole transaction against the copy model.
  task automatic run_cmd(input logic [NW-1:0] wid, input logic [AW-1:0] src,
                         input logic [AW-1:0] dst, input logic [SW-1:0] size,
                         input bit stall, input int hold, input bit chk_lat);
    int            n;
    int            cyc;
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    logic [DW-1:0] v;
    n = int'(size / WS);
    s = src & ~(AW'(WS - 1));
    d = dst & ~(AW'(WS - 1));
    // Copy model: ascending word copy, in place on a snapshot of memory.
    ref_mem = mem;
    exp_rd_q.delete(); exp_wa_q.delete(); exp_q.delete();
    for (int i = 0; i < n; i++) begin
      v = ref_get(s + AW'(WS * i));
      ref_mem[d + AW'(WS * i)] = v;
      exp_rd_q.push_back(s + AW'(WS * i));
      exp_wa_q.push_back(d + AW'(WS * i));
      exp_q.push_back(v);
    end
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    stall_mode = stall;

    req_wid = wid; req_src = src; req_dst = dst; req_size = size;
    req_valid = 1'b1;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_src = $urandom; req_dst = $urandom; req_size = $urandom;
    cyc = 1;
    while (!rsp_valid && cyc < 4000) begin
      check("req_ready_busy", req_ready, 0);
      check("busy_high", busy, 1);
      @(negedge clk);
      cyc++;
    end
    check("rsp_arrived", rsp_valid, 1);
    if (chk_lat) check("rsp_latency", cyc, 3 * n + 1);
    check("rsp_wid", rsp_wid, wid);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("rsp_hold_valid", rsp_valid, 1);
      check("rsp_hold_wid", rsp_wid, wid);
      check("rsp_hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("busy_after_rsp", busy, 0);
    check("req_ready_after_rsp", req_ready, 1);
    check("rsp_valid_after_rsp", rsp_valid, 0);
    stall_mode = 1'b0;

    check("num_reads", rd_log.size(), n);
    check("num_writes", wr_addr_log.size(), n);
    for (int i = 0; i < n && i < rd_log.size(); i++)
      check("rd_addr", rd_log[i], exp_rd_q[i]);
    for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
      check("wr_addr", wr_addr_log[i], exp_wa_q[i]);
      check("wr_data", wr_data_log[i], exp_q[i]);
    end
    for (int i = 0; i < n; i++)
      check("dst_word", mem_get(d + AW'(WS * i)), ref_get(d + AW'(WS * i)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_wid = '0; req_src = '0; req_dst = '0; req_size = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_rsp_ready", mem_rsp_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_wid", rsp_wid, 0);
    check("rst_addr", mem_req_addr, 0);
    check("rst_data", mem_req_data, 0);
    check("rst_byteen", mem_req_byteen, 4'hF);
    reset = 1'b0;
    @(negedge clk);

    // Three-word copy with explicit source words
    mem[32'h100] = 32'hAAAA_0001;
    mem[32'h104] = 32'hBBBB_0002;
    mem[32'h108] = 32'hCCCC_0003;
    run_cmd(2'd2, 32'h100, 32'h200, 32'd12, 1'b0, 0, 1'b1);
    check("tp1_word_a", mem_get(32'h200), 32'hAAAA_0001);
    check("tp1_word_c", mem_get(32'h208), 32'hCCCC_0003);

    // No whole word: immediate response, no traffic
    run_cmd(2'd1, 32'h300, 32'h400, 32'd0, 1'b0, 0, 1'b1);
    run_cmd(2'd1, 32'h300, 32'h400, 32'd3, 1'b0, 0, 1'b1);

    // Unaligned addresses, trailing byte dropped
    run_cmd(2'd3, 32'h103, 32'h207, 32'd9, 1'b0, 0, 1'b1);
    if (rd_log.size() > 0) check("unaligned_rd0", rd_log[0], 32'h100);
    if (wr_addr_log.size() > 0) check("unaligned_wr0", wr_addr_log[0], 32'h204);

    // Sixteen words under random stalls, response held back 5 cycles
    run_cmd(2'd0, 32'h1000, 32'h2000, 32'd64, 1'b1, 5, 1'b0);

    // Source address wraps past the top of the address space
    run_cmd(2'd1, 32'hFFFF_FFFC, 32'h500, 32'd8, 1'b0, 0, 1'b1);
    if (rd_log.size() > 1) check("wrap_rd1", rd_log[1], 32'h0000_0000);

    // Overlapping ranges and src == dst
    run_cmd(2'd2, 32'h600, 32'h604, 32'd16, 1'b0, 0, 1'b1);
    run_cmd(2'd3, 32'h700, 32'h700, 32'd8, 1'b0, 1, 1'b1);

    // Reset while waiting on a read response
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    req_wid = 2'd3; req_src = 32'h800; req_dst = 32'h900; req_size = 32'd16;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_rd_wait", mem_rsp_ready, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_req_ready", req_ready, 1);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_mem_req_valid", mem_req_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_rsp", rsp_valid, 0);
    end
    check("rst_mid_no_writes", wr_addr_log.size(), 0);
    run_cmd(2'd2, 32'h800, 32'h900, 32'd16, 1'b0, 0, 1'b1);

    // Randomized commands, some overlapping, some stalled
    for (int k = 0; k < 10; k++) begin
      logic [NW-1:0] w;
      logic [AW-1:0] a_src;
      logic [AW-1:0] a_dst;
      logic [SW-1:0] sz;
      bit            st;
      w     = NW'($urandom_range(0, 3));
      a_src = 32'h8000 + AW'($urandom_range(0, 255));
      a_dst = 32'h8000 + AW'($urandom_range(0, 255));
      sz    = SW'($urandom_range(0, 40));
      st    = ($urandom_range(0, 1) == 1);
      run_cmd(w, a_src, a_dst, sz, st, $urandom_range(0, 3), !st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
